// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Register indices are word offsets inside the 16-byte window (A[3:2]).
package mmio_uart_tx_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] UART_REG_TXDATA = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 4;

    localparam int CTRL_TXEN_BIT  = 0;
    localparam int CTRL_IRQEN_BIT = 1;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO buffering bytes between the bus and the serialiser.
// Head entry is presented combinationally on rdata_o; pushes into a full
// FIFO and pops from an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's single-port bus.
// Registers: TXDATA (push), STATUS, CTRL, reserved. Bytes are queued in
// sync_fifo and shifted out LSB first on a registered, glitch-free line.
// Optional feature: define MMIO_UART_TX_IRQ_EN to add the irq output and
// make CTRL[1] (irq_en) writable.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        hit,
    output logic        uart_tx
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    logic [1:0]       regSel;
    logic             busWrite;
    logic             txWrite;
    logic             statusWrite;
    logic             ctrlWrite;
    logic             fifoPush;
    logic             fifoPop;
    logic [7:0]       fifoHead;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [31:0]      countWide;
    logic [3:0]       countSat;
    data_t            statusWord;
    data_t            ctrlWord;
    logic             unusedBits;

    logic             txEn_q, txEn_d;
    logic             overflow_q, overflow_d;
`ifdef MMIO_UART_TX_IRQ_EN
    logic             irqEn_q, irqEn_d;
    logic             irq_q;
`endif

    uart_state_t      state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic             txLine_q, txLine_d;

    assign hit         = (A[31:4] == BASE_ADDR[31:4]);
    assign regSel      = A[3:2];
    assign busWrite    = WE && hit;
    assign txWrite     = busWrite && (regSel == UART_REG_TXDATA);
    assign statusWrite = busWrite && (regSel == UART_REG_STATUS);
    assign ctrlWrite   = busWrite && (regSel == UART_REG_CTRL);
    assign fifoPush    = txWrite && !fifoFull;
    assign unusedBits  = ^{A[1:0], WD[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifoPush),
        .wdata_i (WD[7:0]),
        .pop_i   (fifoPop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Next-state for CTRL and the sticky overflow flag; full is the pre-edge value.
    always_comb begin
        txEn_d     = txEn_q;
        overflow_d = overflow_q;
`ifdef MMIO_UART_TX_IRQ_EN
        irqEn_d    = irqEn_q;
`endif
        if (ctrlWrite) begin
            txEn_d  = WD[CTRL_TXEN_BIT];
`ifdef MMIO_UART_TX_IRQ_EN
            irqEn_d = WD[CTRL_IRQEN_BIT];
`endif
        end
        if (txWrite && fifoFull) begin
            overflow_d = 1'b1;
        end else if (statusWrite && WD[STATUS_OVF_BIT]) begin
            overflow_d = 1'b0;
        end
    end

    // Control/status register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            txEn_q     <= 1'b1;
            overflow_q <= 1'b0;
`ifdef MMIO_UART_TX_IRQ_EN
            irqEn_q    <= 1'b0;
`endif
        end else begin
            txEn_q     <= txEn_d;
            overflow_q <= overflow_d;
`ifdef MMIO_UART_TX_IRQ_EN
            irqEn_q    <= irqEn_d;
`endif
        end
    end

    // Read-side register images and the combinational read mux.
    always_comb begin
        countWide = 32'(fifoCount);
        countSat  = (countWide > 32'd15) ? 4'hF : countWide[3:0];

        statusWord                                = '0;
        statusWord[STATUS_BUSY_BIT]               = (state_q != UART_IDLE);
        statusWord[STATUS_FULL_BIT]               = fifoFull;
        statusWord[STATUS_EMPTY_BIT]              = fifoEmpty;
        statusWord[STATUS_OVF_BIT]                = overflow_q;
        statusWord[STATUS_COUNT_LSB +: 4]         = countSat;

        ctrlWord                = '0;
        ctrlWord[CTRL_TXEN_BIT] = txEn_q;
`ifdef MMIO_UART_TX_IRQ_EN
        ctrlWord[CTRL_IRQEN_BIT] = irqEn_q;
`endif

        RD = '0;
        if (hit) begin
            case (regSel)
                UART_REG_STATUS: RD = statusWord;
                UART_REG_CTRL:   RD = ctrlWord;
                default:         RD = '0;
            endcase
        end
    end

    // Serialiser next-state: baud countdown, bit index, shifting and line level.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        fifoPop  = 1'b0;
        txLine_d = 1'b1;

        case (state_q)
            UART_IDLE: begin
                if (txEn_q && !fifoEmpty) begin
                    fifoPop  = 1'b1;
                    shift_d  = fifoHead;
                    bitIdx_d = '0;
                    baud_d   = BAUD_RELOAD;
                    state_d  = UART_START;
                end
            end
            UART_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            UART_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bitIdx_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        shift_d  = shift_q >> 1;
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            UART_STOP: begin
                if (baud_q == '0) begin
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase

        // The line is registered from the upcoming state so the start bit
        // appears on the same edge that leaves IDLE.
        case (state_d)
            UART_START: txLine_d = 1'b0;
            UART_DATA:  txLine_d = shift_d[0];
            default:    txLine_d = 1'b1;
        endcase
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UART_IDLE;
            baud_q   <= '0;
            shift_q  <= '0;
            bitIdx_q <= '0;
            txLine_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            txLine_q <= txLine_d;
        end
    end

    assign uart_tx = txLine_q;

`ifdef MMIO_UART_TX_IRQ_EN
    // Interrupt when enabled, nothing queued and the serialiser is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irqEn_q && fifoEmpty && (state_q == UART_IDLE);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x1000).
// Directed bus stimulus pushes expected bytes into a queue; a negedge
// receiver decodes frames off uart_tx and checks them against that queue.
module tb_mmio_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_GAP = 10 * CPB + 1;

    localparam logic [31:0] ADDR_TX     = 32'h0000_1000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_1008;
    localparam logic [31:0] ADDR_RSVD   = 32'h0000_100C;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A     = '0;
    logic [31:0] WD    = '0;
    logic        WE    = 1'b0;
    logic [31:0] RD;
    logic        hit;
    logic        uart_tx;
`ifdef MMIO_UART_TX_IRQ_EN
    logic        irq;
    logic        irqSeen;
`endif

    int          vecCount = 0;
    int          errCount = 0;
    int          cycle    = 0;

    logic [7:0]  expQ[$];
    int          startTimes[$];
    logic        rxActive = 1'b0;
    int          rxPhase  = 0;
    logic [7:0]  rxByte   = '0;
    logic [7:0]  expByte;
    logic        stayedHigh;
    int          expLine[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .WD      (WD),
        .WE      (WE),
        .RD      (RD),
        .hit     (hit),
        .uart_tx (uart_tx)
`ifdef MMIO_UART_TX_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    // Free-running clock and a cycle counter used to timestamp frame starts.
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 32'h%08h, want 32'h%08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // One bus write lasting exactly one rising edge; called at a negedge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expRd, input logic expHit);
        A  = addr;
        WE = 1'b0;
        #1;
        checkOutput(name, RD, expRd);
        checkOutput({name, " hit"}, {31'b0, hit}, {31'b0, expHit});
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n = 0;
        while ((expQ.size() != 0 || rxActive) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " drained"}, {31'b0, (expQ.size() != 0 || rxActive)}, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic checkGaps(input string name, input int nFrames);
        checkOutput({name, " frame count"}, 32'(startTimes.size()), 32'(nFrames));
        for (int i = 1; i < startTimes.size(); i++) begin
            checkOutput({name, " frame spacing"}, 32'(startTimes[i] - startTimes[i-1]), 32'(FRAME_GAP));
        end
    endtask

    // Receiver: detects a start bit, samples mid-bit, and scores each byte.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rxActive = 1'b0;
            end else if (!rxActive) begin
                if (uart_tx === 1'b0) begin
                    rxActive = 1'b1;
                    rxPhase  = 0;
                    rxByte   = '0;
                    startTimes.push_back(cycle);
                end
            end else begin
                rxPhase++;
                if (rxPhase == 2) begin
                    checkOutput("rx start bit", {31'b0, uart_tx}, 32'h0);
                end else if (rxPhase >= 6 && rxPhase <= 34 && ((rxPhase - 6) % 4) == 0) begin
                    rxByte[(rxPhase - 6) / 4] = uart_tx;
                end else if (rxPhase == 38) begin
                    checkOutput("rx stop bit", {31'b0, uart_tx}, 32'h1);
                    if (expQ.size() == 0) begin
                        vecCount++;
                        errCount++;
                        $display("[TB] FAIL rx unexpected frame: got 8'h%02h, want no frame (cycle %0d)", rxByte, cycle);
                    end else begin
                        expByte = expQ.pop_front();
                        checkOutput("rx byte", {24'b0, rxByte}, {24'b0, expByte});
                    end
                    rxActive = 1'b0;
                end
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("line during reset", {31'b0, uart_tx}, 32'h1);
        reset = 1'b0;
        @(negedge clk);

        // Reset state and address decode.
        readCheck("STATUS after reset", ADDR_STATUS, 32'h4, 1'b1);
        readCheck("STATUS low bits ignored", 32'h0000_1007, 32'h4, 1'b1);
        readCheck("CTRL after reset", ADDR_CTRL, 32'h1, 1'b1);
        readCheck("TXDATA reads zero", ADDR_TX, 32'h0, 1'b1);
        readCheck("reserved reads zero", ADDR_RSVD, 32'h0, 1'b1);
        readCheck("miss 0x2000", 32'h0000_2000, 32'h0, 1'b0);
        readCheck("miss 0x1010", 32'h0000_1010, 32'h0, 1'b0);
        applyStimulus(ADDR_RSVD, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_2008, 32'h0000_0000);
        readCheck("reserved after write", ADDR_RSVD, 32'h0, 1'b1);
        readCheck("CTRL after miss write", ADDR_CTRL, 32'h1, 1'b1);
        checkOutput("no frame from miss/reserved", 32'(startTimes.size()), 32'h0);

        // Single frame 0xA5, checked bit-by-bit and through the receiver.
        expQ.push_back(8'hA5);
        applyStimulus(ADDR_TX, 32'h0000_00A5);
        checkOutput("line idle one edge after write", {31'b0, uart_tx}, 32'h1);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                checkOutput($sformatf("A5 frame bit %0d", b), {31'b0, uart_tx}, 32'(expLine[b]));
                if (b == 5 && j == 0) begin
                    readCheck("STATUS busy mid-frame", ADDR_STATUS, 32'h5, 1'b1);
                end
            end
        end
        @(negedge clk);
        readCheck("STATUS idle after frame", ADDR_STATUS, 32'h4, 1'b1);
        waitDrain("A5", 20);

        // Six back-to-back pushes: one popped, four queued, one dropped.
        startTimes.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) begin
                expQ.push_back(8'(i * 17));
            end
            applyStimulus(ADDR_TX, 32'(i * 17));
        end
        readCheck("STATUS full + overflow", ADDR_STATUS, 32'h4B, 1'b1);
        applyStimulus(ADDR_STATUS, 32'h0000_0008);
        readCheck("STATUS overflow cleared", ADDR_STATUS, 32'h43, 1'b1);
        waitDrain("overflow burst", 400);
        checkGaps("overflow burst", 5);
        readCheck("STATUS after burst", ADDR_STATUS, 32'h4, 1'b1);

        // Gated transmitter: bytes queue up, then go out back-to-back.
        startTimes.delete();
        applyStimulus(ADDR_CTRL, 32'h0);
        readCheck("CTRL cleared", ADDR_CTRL, 32'h0, 1'b1);
        expQ.push_back(8'h3C);
        applyStimulus(ADDR_TX, 32'h3C);
        expQ.push_back(8'h81);
        applyStimulus(ADDR_TX, 32'h81);
        expQ.push_back(8'h5A);
        applyStimulus(ADDR_TX, 32'h5A);
        stayedHigh = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayedHigh = 1'b0;
        end
        checkOutput("line held while tx_en=0", {31'b0, stayedHigh}, 32'h1);
        readCheck("STATUS count=3 gated", ADDR_STATUS, 32'h30, 1'b1);
        applyStimulus(ADDR_CTRL, 32'h1);
        waitDrain("gated release", 300);
        checkGaps("gated release", 3);

`ifdef MMIO_UART_TX_IRQ_EN
        // Interrupt: high when idle and empty, low while a frame is in flight.
        applyStimulus(ADDR_CTRL, 32'h3);
        readCheck("CTRL irq_en set", ADDR_CTRL, 32'h3, 1'b1);
        @(negedge clk);
        checkOutput("irq idle", {31'b0, irq}, 32'h1);
        expQ.push_back(8'h7E);
        applyStimulus(ADDR_TX, 32'h7E);
        repeat (10) @(negedge clk);
        checkOutput("irq during frame", {31'b0, irq}, 32'h0);
        irqSeen = 1'b0;
        for (int i = 0; i < 60 && !irqSeen; i++) begin
            @(negedge clk);
            if (!rxActive && expQ.size() == 0 && uart_tx === 1'b1 && irq === 1'b1) irqSeen = 1'b1;
        end
        checkOutput("irq after frame", {31'b0, irqSeen}, 32'h1);
        repeat (4) @(negedge clk);
`else
        // Without the interrupt option CTRL[1] is not writable.
        applyStimulus(ADDR_CTRL, 32'h3);
        readCheck("CTRL irq_en ignored", ADDR_CTRL, 32'h1, 1'b1);
`endif

        // Reset during DATA bit 3, after tx_en was cleared mid-frame.
        startTimes.delete();
        expQ.push_back(8'hC3);
        applyStimulus(ADDR_TX, 32'hC3);
        @(negedge clk);
        checkOutput("reset test start bit", {31'b0, uart_tx}, 32'h0);
        applyStimulus(ADDR_CTRL, 32'h0);
        expQ.push_back(8'h11);
        applyStimulus(ADDR_TX, 32'h11);
        expQ.push_back(8'h22);
        applyStimulus(ADDR_TX, 32'h22);
        repeat (14) @(negedge clk);
        checkOutput("frame continues after tx_en=0 (bit 3)", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("line high after reset", {31'b0, uart_tx}, 32'h1);
        readCheck("STATUS after mid-frame reset", ADDR_STATUS, 32'h4, 1'b1);
        readCheck("CTRL after mid-frame reset", ADDR_CTRL, 32'h1, 1'b1);
`ifdef MMIO_UART_TX_IRQ_EN
        checkOutput("irq after reset", {31'b0, irq}, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        // The aborted frame and the discarded FIFO bytes never reach the line.
        expQ.delete();
        stayedHigh = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayedHigh = 1'b0;
        end
        checkOutput("no frames after reset", {31'b0, stayedHigh}, 32'h1);
        checkOutput("frame starts in reset test", 32'(startTimes.size()), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
